serializador_par_param: RTL and testbench
=========================================

Name: serializador_par_param

Overview:
- Parametrised parallel-to-serial width converter for the PHY transmit path.
- Accepts one IN_W-bit word per handshake and emits it as OUT_W-bit slices, most-significant slice first, one slice per clock.
- pclk_sel selects the active word width: full, half or quarter of IN_W.
- Valid/ready handshakes on both sides, plus a last-slice marker for the downstream framer.

Parameters:
- IN_W, 32: parallel input word width; must be OUT_W*RATIO.
- OUT_W, 8: output slice width.
- RATIO, IN_W/OUT_W (derived, localparam): must be a power of two, at least 4.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enb  input  1  block enable; gates acceptance of new words.
- pclk_sel  input  2  width select: 00 full IN_W, 01 IN_W/2, 10 IN_W/4, 11 illegal.
- in_data  input  IN_W  parallel word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept in_data this cycle.
- out_data  output  OUT_W  current slice.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream consumes slice this cycle.
- out_last  output  1  current slice is the final slice of its word.
- sel_err  output  1  one-cycle pulse: word accepted with pclk_sel=11.

Behaviour:
- Reset (sampled on clk edge while reset=1):
  - Clears the shift register, slice counter, out_data, out_valid, out_last and sel_err to 0; state returns to IDLE.
  - in_ready is forced 0 while reset=1.
- Slice count n, latched at acceptance only:
  - pclk_sel=00: n=RATIO.
  - pclk_sel=01: n=RATIO/2.
  - pclk_sel=10: n=RATIO/4.
  - pclk_sel=11: n=RATIO/4, and sel_err pulses high for the cycle after acceptance.
  - Changing pclk_sel mid-word has no effect on the word in flight.
- Active region: low n*OUT_W bits of in_data; upper bits are ignored.
  - The active region is left-aligned into the shift register.
  - out_data is always the register's top OUT_W bits.
  - For 32/8 with sel=00: in[31:24] first, in[7:0] last.
  - For 32/8 with sel=10: only in[7:0] is emitted.
- States:
  - IDLE: out_valid=0.
  - SHIFT: out_valid=1; slices remaining counted by cnt, with n-1 down to 0.
- Acceptance (accept = in_valid & in_ready):
  - in_ready = enb & !reset & (IDLE | (SHIFT & cnt==0 & out_ready)).
  - The last slice being consumed and a new word being accepted can happen in the same cycle. This gives back-to-back words with no bubble.
- Latency and throughput:
  - First slice is registered, visible the cycle after accept.
  - Throughput is one slice per cycle while out_ready=1.
- Slice transfer (out_valid & out_ready):
  - cnt>0: shift left by OUT_W, decrement cnt.
  - cnt==0 with no accept: go to IDLE, out_valid=0.
  - cnt==0 with accept: reload and stay in SHIFT.
- out_last = SHIFT & cnt==0; registered alongside out_data.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_last and cnt hold stable.
- enb:
  - Deassertion blocks new acceptances only.
  - A word in flight completes normally.
- Reset mid-word: the word is discarded; no further slices are emitted after the reset cycle.
- Design is one always block for sequential logic plus combinational in_ready; no latches; no combinational path from in_data to out_data.

Test Plan:
1. Reset, enb=1, sel=00, in_data=0xA1B2C3D4 valid 1 cycle, out_ready=1 -> out_data A1,B2,C3,D4 on 4 consecutive cycles starting cycle after accept; out_last only with D4; in_ready=1 during D4 cycle; then out_valid=0.
2. sel=01, in_data=0x12345678 -> slices 56,78, out_last on 78. Then sel=10, in_data=0xFFFFFF9A -> single slice 9A with out_last=1.
3. in_valid held high with 0x01020304 then 0x05060708, out_ready=1 -> bytes 01..08 on 8 consecutive cycles, no gap; in_ready high exactly on accept cycles.
4. sel=00, 0xA1B2C3D4, out_ready=0 for 3 cycles while B2 presented -> B2 stable, in_ready=0; after release C3, D4 follow; no loss or duplication.
5. Mode and error handling:
   - Accept with sel=00, then switch sel to 10 during slice 2 -> all 4 slices still emitted.
   - Next word with sel=10 -> 1 slice.
   - Word with sel=11, in_data=0x000000EE -> single slice EE, sel_err high for one cycle.
6. Reset asserted one cycle while C3 of 0xA1B2C3D4 presented -> next cycle out_valid=0, out_last=0, out_data=0. Then sel=00, 0x55667788 -> clean 55,66,77,88. Also: enb=0 with in_valid=1 -> in_ready=0, no output.

Source files
------------

// File: rtl/serializador_par_param.sv
// Parallel-to-serial width converter for the PHY transmit path.
// Words are emitted most-significant slice first, one OUT_W slice per clock, with selectable active width.
module serializador_par_param #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enb,
  input  logic [1:0]       pclk_sel,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             sel_err
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  localparam logic [CW-1:0] CNT_FULL = CW'(RATIO - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(RATIO / 2 - 1);
  localparam logic [CW-1:0] CNT_QUAR = CW'(RATIO / 4 - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state, state_nxt;
  logic [IN_W-1:0] sr;
  logic [IN_W-1:0] load_word;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_load;
  logic            accept;
  logic            xfer;
  logic            cnt_zero;

  assign cnt_zero = (cnt == '0);
  assign accept   = in_valid & in_ready;
  assign xfer     = out_valid & out_ready;

  // Left-align the active low region so the first slice sits at the top of sr.
  always_comb begin
    load_word = in_data;
    cnt_load  = CNT_FULL;
    case (pclk_sel)
      2'b00: begin
        load_word = in_data;
        cnt_load  = CNT_FULL;
      end
      2'b01: begin
        load_word = in_data << (IN_W / 2);
        cnt_load  = CNT_HALF;
      end
      default: begin
        load_word = in_data << (3 * IN_W / 4);
        cnt_load  = CNT_QUAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      sel_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      sel_err <= accept & (pclk_sel == 2'b11);
      if (accept) begin
        sr  <= load_word;
        cnt <= cnt_load;
      end else if (xfer && !cnt_zero) begin
        sr  <= sr << OUT_W;
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (xfer && cnt_zero && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == SHIFT);
    out_last  = (state == SHIFT) & cnt_zero;
    out_data  = sr[IN_W-1 -: OUT_W];
    in_ready  = enb & ~reset &
                ((state == IDLE) | ((state == SHIFT) & cnt_zero & out_ready));
  end

endmodule

// File: tb/tb_serializador_par_param.sv
// Directed bench for serializador_par_param at 32/8: slicing, width modes, back-to-back, backpressure, reset, enable.
module tb_serializador_par_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        enb;
  logic [1:0]  pclk_sel;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        sel_err;

  int checks = 0;
  int failures = 0;

  serializador_par_param #(.IN_W(32), .OUT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .enb       (enb),
    .pclk_sel  (pclk_sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .sel_err   (sel_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic slice(input string tag, input logic [7:0] d, input logic last);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_last"}, 32'(out_last), 32'(last));
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_last"}, 32'(out_last), 32'd0);
  endtask

  task automatic offer(input logic [1:0] sel, input logic [31:0] d);
    pclk_sel = sel;
    in_data  = d;
    in_valid = 1'b1;
  endtask

  initial begin
    reset = 1'b1; enb = 1'b1; pclk_sel = 2'b00; in_data = '0;
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    step(); step();
    reset = 1'b0;
    #1;
    idle_chk("rst");
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_sel_err", 32'(sel_err), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // 1: full width
    offer(2'b00, 32'hA1B2C3D4);
    step(); in_valid = 1'b0;
    slice("t1_s0", 8'hA1, 1'b0);
    chk("t1_rdy_s0", 32'(in_ready), 32'd0);
    step(); slice("t1_s1", 8'hB2, 1'b0);
    step(); slice("t1_s2", 8'hC3, 1'b0);
    step(); slice("t1_s3", 8'hD4, 1'b1);
    chk("t1_rdy_s3", 32'(in_ready), 32'd1);
    step(); idle_chk("t1_end");

    // 2: half and quarter width
    offer(2'b01, 32'h12345678);
    step(); in_valid = 1'b0;
    slice("t2_h0", 8'h56, 1'b0);
    step(); slice("t2_h1", 8'h78, 1'b1);
    step(); idle_chk("t2_hend");
    offer(2'b10, 32'hFFFFFF9A);
    step(); in_valid = 1'b0;
    slice("t2_q0", 8'h9A, 1'b1);
    step(); idle_chk("t2_qend");

    // 3: back-to-back words, no bubble
    offer(2'b00, 32'h01020304);
    chk("t3_rdy_a", 32'(in_ready), 32'd1);
    step();
    in_data = 32'h05060708;
    slice("t3_b0", 8'h01, 1'b0); chk("t3_rdy0", 32'(in_ready), 32'd0);
    step(); slice("t3_b1", 8'h02, 1'b0); chk("t3_rdy1", 32'(in_ready), 32'd0);
    step(); slice("t3_b2", 8'h03, 1'b0); chk("t3_rdy2", 32'(in_ready), 32'd0);
    step(); slice("t3_b3", 8'h04, 1'b1); chk("t3_rdy3", 32'(in_ready), 32'd1);
    step(); in_valid = 1'b0;
    slice("t3_b4", 8'h05, 1'b0); chk("t3_rdy4", 32'(in_ready), 32'd0);
    step(); slice("t3_b5", 8'h06, 1'b0);
    step(); slice("t3_b6", 8'h07, 1'b0);
    step(); slice("t3_b7", 8'h08, 1'b1);
    step(); idle_chk("t3_end");

    // 4: backpressure on second slice
    offer(2'b00, 32'hA1B2C3D4);
    step(); in_valid = 1'b0;
    slice("t4_s0", 8'hA1, 1'b0);
    step(); slice("t4_s1", 8'hB2, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold_rdy", 32'(in_ready), 32'd0);
      step(); slice("t4_hold", 8'hB2, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step(); slice("t4_s2", 8'hC3, 1'b0);
    step(); slice("t4_s3", 8'hD4, 1'b1);
    step(); idle_chk("t4_end");

    // 5: mid-word sel change, quarter word, illegal sel
    offer(2'b00, 32'hA1B2C3D4);
    step(); in_valid = 1'b0;
    slice("t5_s0", 8'hA1, 1'b0);
    step(); slice("t5_s1", 8'hB2, 1'b0);
    pclk_sel = 2'b10;
    step(); slice("t5_s2", 8'hC3, 1'b0);
    step(); slice("t5_s3", 8'hD4, 1'b1);
    offer(2'b10, 32'h11223344);
    step();
    slice("t5_q", 8'h44, 1'b1);
    chk("t5_q_err", 32'(sel_err), 32'd0);
    chk("t5_q_rdy", 32'(in_ready), 32'd1);
    offer(2'b11, 32'h000000EE);
    step(); in_valid = 1'b0;
    slice("t5_e", 8'hEE, 1'b1);
    chk("t5_e_err", 32'(sel_err), 32'd1);
    step(); idle_chk("t5_end");
    chk("t5_err_clr", 32'(sel_err), 32'd0);

    // 6: reset mid-word, clean restart, enable gating
    pclk_sel = 2'b00;
    offer(2'b00, 32'hA1B2C3D4);
    step(); in_valid = 1'b0;
    step(); step(); slice("t6_c3", 8'hC3, 1'b0);
    reset = 1'b1;
    #1 chk("t6_rst_rdy", 32'(in_ready), 32'd0);
    step(); reset = 1'b0;
    idle_chk("t6_rst");
    chk("t6_rst_data", 32'(out_data), 32'd0);
    step(); idle_chk("t6_rst2");
    offer(2'b00, 32'h55667788);
    step(); in_valid = 1'b0;
    slice("t6_s0", 8'h55, 1'b0);
    step(); slice("t6_s1", 8'h66, 1'b0);
    step(); slice("t6_s2", 8'h77, 1'b0);
    step(); slice("t6_s3", 8'h88, 1'b1);
    step(); idle_chk("t6_end");
    enb = 1'b0;
    offer(2'b00, 32'hCAFEF00D);
    #1 chk("t6_enb_rdy", 32'(in_ready), 32'd0);
    step(); idle_chk("t6_enb0");
    step(); idle_chk("t6_enb1");
    in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
